// File: rtl/mem_map_bridge_if.sv
// ---------------------------------------------------------------------------
// mem_map_bridge_if
//   Core-side load/store handshake for mem_map_bridge.
//   The requester raises req with we/addr/wdata and holds them until ack.
//   The bridge answers with a one-cycle ack pulse. err qualifies that ack,
//   and rdata is meaningful only when ack=1 and err=0.
//
//   Signals:
//     req    requester -> bridge  access request, held until ack
//     we     requester -> bridge  1 = write, 0 = read
//     addr   requester -> bridge  byte address
//     wdata  requester -> bridge  write data
//     rdata  bridge -> requester  read data
//     ack    bridge -> requester  one-cycle response pulse
//     err    bridge -> requester  access faulted
//
//   Modports:
//     master  requester (core) side
//     slave   bridge side
// ---------------------------------------------------------------------------
interface mem_map_bridge_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;
  logic              err;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ack, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ack, err
  );
endinterface

// File: rtl/mem_map_bridge.sv
// ---------------------------------------------------------------------------
// mem_map_bridge
//   Table-driven memory-map decoder and bus bridge between the core's
//   load/store port and up to NUM_REGIONS memory-mapped devices.
//   Each region has an inclusive [base, limit] byte range, a read latency
//   in cycles and a write-permission bit. Accesses that are misaligned,
//   unmapped or write-protected complete with err=1 and never select a
//   device. The first such fault is held in a sticky fault register.
//
//   Ports:
//     clk          system clock, rising edge
//     rst_n        synchronous active-low reset
//     bus          core handshake (req/we/addr/wdata -> rdata/ack/err)
//     dev_sel      one-hot device select
//     dev_we       device write strobe, one cycle per write
//     dev_addr     region-relative word offset
//     dev_wdata    registered write data
//     dev_rdata    per-device read data, slice i belongs to region i
//     fault_valid  sticky fault flag
//     fault_code   01 unmapped, 10 write-protect, 11 misaligned
//     fault_addr   byte address of the first faulting access
//     fault_clr    clears the fault register
//
//   Timing (accept edge at the end of cycle T):
//     read  : dev_sel high in T+1..T+LAT, ack in T+LAT+1
//     write : dev_sel/dev_we high in T+1 only, ack in T+2
//     fault : no dev_sel, ack+err in T+2
// ---------------------------------------------------------------------------
module mem_map_bridge #(
  parameter int                            NUM_REGIONS  = 3,
  parameter int                            ADDR_W       = 16,
  parameter int                            DATA_W       = 16,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE  = {16'h8000, 16'h7000, 16'h0000},
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_LIMIT = {16'hFFFF, 16'h7003, 16'h6FFF},
  parameter logic [NUM_REGIONS*4-1:0]      REGION_LAT   = {4'd1, 4'd2, 4'd1},
  parameter logic [NUM_REGIONS-1:0]        REGION_WR    = 3'b110
) (
  input  logic                          clk,
  input  logic                          rst_n,
  mem_map_bridge_if.slave               bus,
  output logic [NUM_REGIONS-1:0]        dev_sel,
  output logic                          dev_we,
  output logic [ADDR_W-2:0]             dev_addr,
  output logic [DATA_W-1:0]             dev_wdata,
  input  logic [NUM_REGIONS*DATA_W-1:0] dev_rdata,
  output logic                          fault_valid,
  output logic [1:0]                    fault_code,
  output logic [ADDR_W-1:0]             fault_addr,
  input  logic                          fault_clr
);

  localparam int RIDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

  localparam logic [1:0] CODE_NONE     = 2'b00;
  localparam logic [1:0] CODE_UNMAPPED = 2'b01;
  localparam logic [1:0] CODE_WPROT    = 2'b10;
  localparam logic [1:0] CODE_MISALIGN = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // Region table: per-region range match and latency sanity check.
  // A region with base > limit can never match, which disables it.
  // -------------------------------------------------------------------------
  logic [NUM_REGIONS-1:0] match;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGIONS; gi++) begin : g_region
      localparam logic [ADDR_W-1:0] BASE  = REGION_BASE[gi*ADDR_W +: ADDR_W];
      localparam logic [ADDR_W-1:0] LIMIT = REGION_LIMIT[gi*ADDR_W +: ADDR_W];

      if (REGION_LAT[gi*4 +: 4] == 4'd0) begin : g_bad_lat
        $error("mem_map_bridge: REGION_LAT entry must be in 1..15");
      end

      assign match[gi] = (bus.addr >= BASE) && (bus.addr <= LIMIT);
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Priority decode: lowest matching index wins, so scan downwards and let
  // the last hit overwrite the earlier ones.
  // -------------------------------------------------------------------------
  logic              hit;
  logic [RIDX_W-1:0] win_idx;
  logic [ADDR_W-1:0] win_base;
  logic [3:0]        win_lat;
  logic              win_wr;
  logic [ADDR_W-1:0] off_full;
  logic [ADDR_W-2:0] dec_offset;
  logic [1:0]        dec_code;
  logic              unused_off_bit;

  always_comb begin
    hit      = 1'b0;
    win_idx  = '0;
    win_base = '0;
    win_lat  = 4'd1;
    win_wr   = 1'b0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit      = 1'b1;
        win_idx  = RIDX_W'(i);
        win_base = REGION_BASE[i*ADDR_W +: ADDR_W];
        win_lat  = REGION_LAT[i*4 +: 4];
        win_wr   = REGION_WR[i];
      end
    end

    // Modulo-2^ADDR_W subtraction; the byte bit is dropped to form a word
    // offset (it is always 0 for accesses that reach a device).
    off_full       = bus.addr - win_base;
    dec_offset     = off_full[ADDR_W-1:1];
    unused_off_bit = off_full[0];

    // Misaligned outranks unmapped, which outranks write-protect.
    if (bus.addr[0]) begin
      dec_code = CODE_MISALIGN;
    end else if (!hit) begin
      dec_code = CODE_UNMAPPED;
    end else if (bus.we && !win_wr) begin
      dec_code = CODE_WPROT;
    end else begin
      dec_code = CODE_NONE;
    end
  end

  // -------------------------------------------------------------------------
  // State and registered outputs
  // -------------------------------------------------------------------------
  state_t                   state_reg, state_next;
  logic [3:0]               cnt_reg, cnt_next;
  logic [3:0]               lat_reg, lat_next;
  logic [RIDX_W-1:0]        region_reg, region_next;
  logic                     wr_reg, wr_next;
  logic [1:0]               code_reg, code_next;
  logic [ADDR_W-1:0]        addr_reg, addr_next;

  logic [NUM_REGIONS-1:0]   dev_sel_reg, dev_sel_next;
  logic                     dev_we_reg, dev_we_next;
  logic [ADDR_W-2:0]        dev_addr_reg, dev_addr_next;
  logic [DATA_W-1:0]        dev_wdata_reg, dev_wdata_next;
  logic [DATA_W-1:0]        rdata_reg, rdata_next;
  logic                     ack_reg, ack_next;
  logic                     err_reg, err_next;

  logic                     fault_valid_reg, fault_valid_next;
  logic [1:0]               fault_code_reg, fault_code_next;
  logic [ADDR_W-1:0]        fault_addr_reg, fault_addr_next;

  logic                     fault_capture;

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    lat_next       = lat_reg;
    region_next    = region_reg;
    wr_next        = wr_reg;
    code_next      = code_reg;
    addr_next      = addr_reg;
    dev_sel_next   = dev_sel_reg;
    dev_we_next    = 1'b0;
    dev_addr_next  = dev_addr_reg;
    dev_wdata_next = dev_wdata_reg;
    rdata_next     = rdata_reg;
    ack_next       = 1'b0;
    err_next       = 1'b0;
    fault_capture  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.req) begin
          wr_next   = bus.we;
          code_next = dec_code;
          addr_next = bus.addr;
          // A faulting access still spends one cycle in ACCESS (with no
          // device selected) so that its ack lines up with a write ack.
          state_next = ACCESS;
          if (dec_code == CODE_NONE) begin
            region_next    = win_idx;
            lat_next       = win_lat;
            cnt_next       = 4'd1;
            dev_sel_next   = NUM_REGIONS'(1) << win_idx;
            dev_we_next    = bus.we;
            dev_addr_next  = dec_offset;
            dev_wdata_next = bus.wdata;
          end
        end
      end

      ACCESS: begin
        if (code_reg != CODE_NONE) begin
          state_next    = RESP;
          ack_next      = 1'b1;
          err_next      = 1'b1;
          rdata_next    = '0;
          fault_capture = 1'b1;
        end else if (wr_reg) begin
          state_next   = RESP;
          dev_sel_next = '0;
          ack_next     = 1'b1;
          rdata_next   = '0;
        end else if (cnt_reg == lat_reg) begin
          // Last select cycle: sample the selected device's data.
          state_next   = RESP;
          dev_sel_next = '0;
          ack_next     = 1'b1;
          rdata_next   = dev_rdata[region_reg*DATA_W +: DATA_W];
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end

      RESP: begin
        // req is deliberately not looked at here: the earliest new accept
        // is the IDLE cycle that follows the ack.
        state_next = IDLE;
        rdata_next = '0;
      end

      default: begin
        state_next   = IDLE;
        dev_sel_next = '0;
      end
    endcase
  end

  // Fault register: clear first, then let a capture override it so that a
  // simultaneous clear and new fault keeps the new fault.
  always_comb begin
    fault_valid_next = fault_valid_reg;
    fault_code_next  = fault_code_reg;
    fault_addr_next  = fault_addr_reg;
    if (fault_clr) begin
      fault_valid_next = 1'b0;
      fault_code_next  = 2'b00;
      fault_addr_next  = '0;
    end
    if (fault_capture && (!fault_valid_reg || fault_clr)) begin
      fault_valid_next = 1'b1;
      fault_code_next  = code_reg;
      fault_addr_next  = addr_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      cnt_reg         <= 4'd0;
      lat_reg         <= 4'd0;
      region_reg      <= '0;
      wr_reg          <= 1'b0;
      code_reg        <= CODE_NONE;
      addr_reg        <= '0;
      dev_sel_reg     <= '0;
      dev_we_reg      <= 1'b0;
      dev_addr_reg    <= '0;
      dev_wdata_reg   <= '0;
      rdata_reg       <= '0;
      ack_reg         <= 1'b0;
      err_reg         <= 1'b0;
      fault_valid_reg <= 1'b0;
      fault_code_reg  <= 2'b00;
      fault_addr_reg  <= '0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      lat_reg         <= lat_next;
      region_reg      <= region_next;
      wr_reg          <= wr_next;
      code_reg        <= code_next;
      addr_reg        <= addr_next;
      dev_sel_reg     <= dev_sel_next;
      dev_we_reg      <= dev_we_next;
      dev_addr_reg    <= dev_addr_next;
      dev_wdata_reg   <= dev_wdata_next;
      rdata_reg       <= rdata_next;
      ack_reg         <= ack_next;
      err_reg         <= err_next;
      fault_valid_reg <= fault_valid_next;
      fault_code_reg  <= fault_code_next;
      fault_addr_reg  <= fault_addr_next;
    end
  end

  assign bus.rdata   = rdata_reg;
  assign bus.ack     = ack_reg;
  assign bus.err     = err_reg;
  assign dev_sel     = dev_sel_reg;
  assign dev_we      = dev_we_reg;
  assign dev_addr    = dev_addr_reg;
  assign dev_wdata   = dev_wdata_reg;
  assign fault_valid = fault_valid_reg;
  assign fault_code  = fault_code_reg;
  assign fault_addr  = fault_addr_reg;

endmodule

// File: tb/tb_mem_map_bridge.sv
// ---------------------------------------------------------------------------
// tb_mem_map_bridge
//   Directed and randomized checks of mem_map_bridge against a reference
//   model built from the region table (base/limit/latency/write mask).
// ---------------------------------------------------------------------------
module tb_mem_map_bridge;
  localparam int NR = 3;
  localparam int AW = 16;
  localparam int DW = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              fault_clr = 1'b0;
  logic [NR-1:0]     dev_sel;
  logic              dev_we;
  logic [AW-2:0]     dev_addr;
  logic [DW-1:0]     dev_wdata;
  logic [NR*DW-1:0]  dev_rdata = '0;
  logic              fault_valid;
  logic [1:0]        fault_code;
  logic [AW-1:0]     fault_addr;

  always #5 clk = ~clk;

  mem_map_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_map_bridge dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .dev_sel    (dev_sel),
    .dev_we     (dev_we),
    .dev_addr   (dev_addr),
    .dev_wdata  (dev_wdata),
    .dev_rdata  (dev_rdata),
    .fault_valid(fault_valid),
    .fault_code (fault_code),
    .fault_addr (fault_addr),
    .fault_clr  (fault_clr)
  );

  // Reference region table (index 0 = ROM, 1 = UART, 2 = RAM)
  int unsigned ref_base [NR] = '{32'h0000, 32'h7000, 32'h8000};
  int unsigned ref_limit[NR] = '{32'h6FFF, 32'h7003, 32'hFFFF};
  int          ref_lat  [NR] = '{1, 2, 1};
  bit          ref_wr   [NR] = '{1'b0, 1'b1, 1'b1};

  typedef struct packed {
    logic [1:0] code;
    logic [7:0] region;
    logic [3:0] lat;
  } dec_t;

  function automatic dec_t model_decode(input logic [AW-1:0] a, input logic w);
    dec_t d;
    int   r;
    r = -1;
    for (int i = 0; i < NR; i++)
      if (r < 0 && a >= ref_base[i] && a <= ref_limit[i]) r = i;
    d.region = (r >= 0) ? 8'(r) : 8'd0;
    d.lat    = (r >= 0) ? 4'(ref_lat[r]) : 4'd0;
    if (a[0])                    d.code = 2'b11;
    else if (r < 0)              d.code = 2'b01;
    else if (w && !ref_wr[r])    d.code = 2'b10;
    else                         d.code = 2'b00;
    return d;
  endfunction

  int errors = 0;
  int checks = 0;

  // Per-access observations gathered by drive_access
  logic [NR-1:0] obs_sel [0:40];
  logic          obs_we  [0:40];
  int            obs_ack_cycle;
  int            obs_acks;
  logic          obs_err;
  logic [DW-1:0] obs_rdata;
  logic [AW-2:0] obs_daddr;
  logic [DW-1:0] obs_dwdata;

  logic          exp_fv;
  logic [1:0]    exp_fc;
  logic [AW-1:0] exp_fa;

  // Issue one request in the current cycle (T = 0) and record outputs each
  // cycle until the cycle after the ack. fault_clr is held for clr_cycles.
  task automatic drive_access(input logic w, input logic [AW-1:0] a,
                              input logic [DW-1:0] wd, input int clr_cycles);
    bus.req   = 1'b1;
    bus.we    = w;
    bus.addr  = a;
    bus.wdata = wd;
    fault_clr = (clr_cycles > 0);
    obs_ack_cycle = -1;
    obs_acks  = 0;
    obs_err   = 1'b0;
    obs_rdata = '0;
    for (int k = 0; k <= 40; k++) begin
      obs_sel[k] = '0;
      obs_we[k]  = 1'b0;
    end
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      fault_clr  = (k < clr_cycles);
      obs_sel[k] = dev_sel;
      obs_we[k]  = dev_we;
      if (k == 1) begin
        obs_daddr  = dev_addr;
        obs_dwdata = dev_wdata;
      end
      if (bus.ack) begin
        obs_acks++;
        if (obs_ack_cycle < 0) begin
          obs_ack_cycle = k;
          obs_err   = bus.err;
          obs_rdata = bus.rdata;
        end
        bus.req = 1'b0;
      end else if (obs_ack_cycle > 0) begin
        break;
      end
    end
    bus.req   = 1'b0;
    fault_clr = 1'b0;
  endtask

  task automatic test_reset();
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 16'h8000; bus.wdata = 16'hAAAA;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.ack, bus.err, bus.rdata, dev_sel, dev_we, dev_addr, dev_wdata,
         fault_valid, fault_code, fault_addr} !== 72'h0) begin
      errors++;
      $display("FAIL reset_outputs: got ack=%b err=%b rdata=%h sel=%b we=%b daddr=%h dwdata=%h fv=%b fc=%b fa=%h, expected all 0",
               bus.ack, bus.err, bus.rdata, dev_sel, dev_we, dev_addr, dev_wdata,
               fault_valid, fault_code, fault_addr);
    end
    bus.req = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({bus.ack, dev_sel} !== 4'b0) begin
      errors++;
      $display("FAIL reset_release_idle: got ack=%b sel=%b, expected 0", bus.ack, dev_sel);
    end
    $display("reset: done");
  endtask

  task automatic test_reads();
    dev_rdata = {16'h5A5A, 16'h0041, 16'hBEEF};
    drive_access(1'b0, 16'h0010, 16'h0000, 0);
    checks++;
    if (obs_sel[1] !== 3'b001) begin errors++; $display("FAIL rom_sel: got %b expected 001", obs_sel[1]); end
    checks++;
    if (obs_daddr !== 15'h0008) begin errors++; $display("FAIL rom_daddr: got %h expected 0008", obs_daddr); end
    checks++;
    if (obs_ack_cycle !== 2 || obs_acks !== 1) begin errors++; $display("FAIL rom_ack: got cycle %0d count %0d expected cycle 2 count 1", obs_ack_cycle, obs_acks); end
    checks++;
    if ({obs_err, obs_rdata} !== {1'b0, 16'hBEEF}) begin errors++; $display("FAIL rom_rdata: got err=%b rdata=%h expected err=0 rdata=beef", obs_err, obs_rdata); end
    $display("read rom 0x0010: ack@%0d rdata=%h", obs_ack_cycle, obs_rdata);

    drive_access(1'b0, 16'h7002, 16'h0000, 0);
    checks++;
    if ({obs_sel[1], obs_sel[2], obs_sel[3]} !== {3'b010, 3'b010, 3'b000}) begin
      errors++; $display("FAIL uart_sel: got %b %b %b expected 010 010 000", obs_sel[1], obs_sel[2], obs_sel[3]);
    end
    checks++;
    if (obs_daddr !== 15'h0001) begin errors++; $display("FAIL uart_daddr: got %h expected 0001", obs_daddr); end
    checks++;
    if (obs_ack_cycle !== 3 || obs_acks !== 1) begin errors++; $display("FAIL uart_ack: got cycle %0d count %0d expected cycle 3 count 1", obs_ack_cycle, obs_acks); end
    checks++;
    if ({obs_err, obs_rdata} !== {1'b0, 16'h0041}) begin errors++; $display("FAIL uart_rdata: got err=%b rdata=%h expected err=0 rdata=0041", obs_err, obs_rdata); end
    $display("read uart 0x7002: ack@%0d rdata=%h", obs_ack_cycle, obs_rdata);
  endtask

  task automatic test_write();
    drive_access(1'b1, 16'h8004, 16'h1234, 0);
    checks++;
    if ({obs_sel[1], obs_we[1], obs_sel[2], obs_we[2]} !== {3'b100, 1'b1, 3'b000, 1'b0}) begin
      errors++; $display("FAIL ram_write_strobe: got sel1=%b we1=%b sel2=%b we2=%b expected 100 1 000 0", obs_sel[1], obs_we[1], obs_sel[2], obs_we[2]);
    end
    checks++;
    if ({obs_daddr, obs_dwdata} !== {15'h0002, 16'h1234}) begin
      errors++; $display("FAIL ram_write_addr_data: got daddr=%h dwdata=%h expected 0002 1234", obs_daddr, obs_dwdata);
    end
    checks++;
    if (obs_ack_cycle !== 2 || obs_acks !== 1 || obs_err !== 1'b0 || obs_rdata !== 16'h0) begin
      errors++; $display("FAIL ram_write_ack: got cycle %0d count %0d err=%b rdata=%h expected 2 1 0 0000", obs_ack_cycle, obs_acks, obs_err, obs_rdata);
    end
    $display("write ram 0x8004=1234: ack@%0d err=%b", obs_ack_cycle, obs_err);
  endtask

  task automatic test_faults();
    drive_access(1'b1, 16'h0020, 16'hDEAD, 0);
    checks++;
    if ({obs_sel[1], obs_sel[2], obs_we[1]} !== 7'b0) begin errors++; $display("FAIL wprot_no_sel: got sel1=%b sel2=%b we1=%b expected 0", obs_sel[1], obs_sel[2], obs_we[1]); end
    checks++;
    if (obs_ack_cycle !== 2 || obs_err !== 1'b1 || obs_rdata !== 16'h0) begin errors++; $display("FAIL wprot_ack: got cycle %0d err=%b rdata=%h expected 2 1 0000", obs_ack_cycle, obs_err, obs_rdata); end
    checks++;
    if ({fault_valid, fault_code, fault_addr} !== {1'b1, 2'b10, 16'h0020}) begin
      errors++; $display("FAIL wprot_fault: got fv=%b fc=%b fa=%h expected 1 10 0020", fault_valid, fault_code, fault_addr);
    end
    $display("write rom 0x0020: err=%b fault=%b/%h", obs_err, fault_code, fault_addr);

    drive_access(1'b0, 16'h7800, 16'h0000, 0);
    checks++;
    if (obs_ack_cycle !== 2 || obs_err !== 1'b1 || obs_sel[1] !== 3'b000) begin errors++; $display("FAIL unmapped_ack: got cycle %0d err=%b sel=%b expected 2 1 000", obs_ack_cycle, obs_err, obs_sel[1]); end
    checks++;
    if ({fault_valid, fault_code, fault_addr} !== {1'b1, 2'b10, 16'h0020}) begin
      errors++; $display("FAIL fault_sticky: got fv=%b fc=%b fa=%h expected 1 10 0020", fault_valid, fault_code, fault_addr);
    end
    $display("read unmapped 0x7800: err=%b fault=%b/%h", obs_err, fault_code, fault_addr);

    drive_access(1'b0, 16'h0003, 16'h0000, 2);
    checks++;
    if (obs_err !== 1'b1 || {fault_valid, fault_code, fault_addr} !== {1'b1, 2'b11, 16'h0003}) begin
      errors++; $display("FAIL clr_and_capture: got err=%b fv=%b fc=%b fa=%h expected 1 1 11 0003", obs_err, fault_valid, fault_code, fault_addr);
    end
    $display("read misaligned 0x0003 with clear: fault=%b/%h", fault_code, fault_addr);

    fault_clr = 1'b1;
    @(posedge clk); #1;
    fault_clr = 1'b0;
    checks++;
    if ({fault_valid, fault_code, fault_addr} !== 19'h0) begin
      errors++; $display("FAIL fault_clear: got fv=%b fc=%b fa=%h expected 0", fault_valid, fault_code, fault_addr);
    end
    $display("fault clear: fv=%b", fault_valid);
  endtask

  task automatic test_back_to_back();
    int period;
    logic [DW-1:0] exp_rd;
    period = ref_lat[2] + 2;
    dev_rdata = {16'hC0DE, 16'h1111, 16'h2222};
    exp_rd = 16'hC0DE;
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 16'h8000; bus.wdata = '0;
    for (int k = 1; k <= 3 * period; k++) begin
      @(posedge clk); #1;
      if (k == 3 * period) bus.req = 1'b0;
      checks++;
      if (bus.ack !== ((k % period) == period - 1) ||
          dev_sel !== (((k % period) >= 1 && (k % period) <= ref_lat[2]) ? 3'b100 : 3'b000)) begin
        errors++; $display("FAIL b2b_cycle%0d: got ack=%b sel=%b", k, bus.ack, dev_sel);
      end
      if (bus.ack) begin
        checks++;
        if (bus.rdata !== exp_rd || bus.err !== 1'b0) begin
          errors++; $display("FAIL b2b_rdata: got err=%b rdata=%h expected 0 %h", bus.err, bus.rdata, exp_rd);
        end
        $display("b2b read 0x8000: ack@%0d rdata=%h", k, bus.rdata);
      end
    end
    @(posedge clk); #1;
    checks++;
    if ({bus.ack, dev_sel} !== 4'b0) begin errors++; $display("FAIL b2b_idle: got ack=%b sel=%b expected 0", bus.ack, dev_sel); end
  endtask

  task automatic test_reset_mid();
    int stray_acks;
    dev_rdata = {16'h0000, 16'h00A5, 16'h0000};
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 16'h7002; bus.wdata = 16'h0;
    @(posedge clk); #1;
    checks++;
    if (dev_sel !== 3'b010) begin errors++; $display("FAIL mid_sel_before_reset: got %b expected 010", dev_sel); end
    rst_n = 1'b0;
    bus.req = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({bus.ack, bus.err, bus.rdata, dev_sel, dev_we, dev_addr, dev_wdata,
         fault_valid, fault_code, fault_addr} !== 72'h0) begin
      errors++; $display("FAIL mid_reset_outputs: got ack=%b rdata=%h sel=%b daddr=%h expected all 0", bus.ack, bus.rdata, dev_sel, dev_addr);
    end
    stray_acks = 0;
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.ack) stray_acks++;
    end
    checks++;
    if (stray_acks !== 0) begin errors++; $display("FAIL mid_reset_no_ack: got %0d acks expected 0", stray_acks); end
    drive_access(1'b0, 16'h7000, 16'h0000, 0);
    checks++;
    if (obs_ack_cycle !== 3 || obs_err !== 1'b0 || obs_rdata !== 16'h00A5 || obs_daddr !== 15'h0) begin
      errors++; $display("FAIL post_reset_read: got cycle %0d err=%b rdata=%h daddr=%h expected 3 0 00a5 0000", obs_ack_cycle, obs_err, obs_rdata, obs_daddr);
    end
    $display("reset mid-access then read 0x7000: ack@%0d rdata=%h", obs_ack_cycle, obs_rdata);
  endtask

  task automatic test_random();
    logic [AW-1:0] edges [12];
    logic [AW-1:0] a;
    logic          w;
    logic [DW-1:0] wd;
    dec_t          d;
    logic          ok;
    int            exp_ack;
    int            sel_cycles;
    logic [NR-1:0] exp_sel;
    edges = '{16'h0000, 16'h0001, 16'h6FFE, 16'h6FFF, 16'h7000, 16'h7002,
              16'h7003, 16'h7004, 16'h7FFE, 16'h8000, 16'hFFFE, 16'hFFFF};
    exp_fv = 1'b0; exp_fc = 2'b00; exp_fa = '0;
    for (int n = 0; n < 48; n++) begin
      a  = ($urandom_range(0, 2) == 0) ? edges[$urandom_range(0, 11)] : AW'($urandom);
      w  = 1'($urandom);
      wd = DW'($urandom);
      dev_rdata = {DW'($urandom), DW'($urandom), DW'($urandom)};
      d  = model_decode(a, w);
      ok = (d.code == 2'b00);
      exp_ack    = (!ok || w) ? 2 : int'(d.lat) + 1;
      sel_cycles = !ok ? 0 : (w ? 1 : int'(d.lat));
      drive_access(w, a, wd, 0);

      checks++;
      if (obs_ack_cycle !== exp_ack || obs_acks !== 1) begin
        errors++; $display("FAIL rnd_ack a=%h we=%b: got cycle %0d count %0d expected cycle %0d count 1", a, w, obs_ack_cycle, obs_acks, exp_ack);
      end
      checks++;
      if (obs_err !== !ok || obs_rdata !== ((ok && !w) ? dev_rdata[d.region*DW +: DW] : 16'h0)) begin
        errors++; $display("FAIL rnd_resp a=%h we=%b: got err=%b rdata=%h expected err=%b rdata=%h", a, w, obs_err, obs_rdata, !ok,
                           (ok && !w) ? dev_rdata[d.region*DW +: DW] : 16'h0);
      end
      for (int k = 1; k <= exp_ack + 1; k++) begin
        exp_sel = (k <= sel_cycles) ? NR'(1) << d.region : '0;
        checks++;
        if ({obs_sel[k], obs_we[k]} !== {exp_sel, (ok && w && k == 1)}) begin
          errors++; $display("FAIL rnd_sel a=%h we=%b cycle %0d: got sel=%b we=%b expected sel=%b we=%b", a, w, k, obs_sel[k], obs_we[k], exp_sel, (ok && w && k == 1));
        end
      end
      if (ok) begin
        checks++;
        if (obs_daddr !== AW'((a - ref_base[d.region]) / 2) >> 0 || (w && obs_dwdata !== wd)) begin
          errors++; $display("FAIL rnd_dev a=%h we=%b: got daddr=%h dwdata=%h expected daddr=%h dwdata=%h", a, w, obs_daddr, obs_dwdata,
                             (a - ref_base[d.region]) / 2, wd);
        end
      end
      if (!ok && !exp_fv) begin
        exp_fv = 1'b1; exp_fc = d.code; exp_fa = a;
      end
      checks++;
      if ({fault_valid, fault_code, fault_addr} !== {exp_fv, exp_fc, exp_fa}) begin
        errors++; $display("FAIL rnd_fault a=%h: got fv=%b fc=%b fa=%h expected fv=%b fc=%b fa=%h", a, fault_valid, fault_code, fault_addr, exp_fv, exp_fc, exp_fa);
      end
      $display("rnd %0d: %s a=%h wd=%h code=%b ack@%0d err=%b rdata=%h", n, w ? "wr" : "rd", a, wd, d.code, obs_ack_cycle, obs_err, obs_rdata);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
    test_reset();
    test_reads();
    test_write();
    test_faults();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
